// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if
//   Bundles the two requester Avalon-MM ports, the shared slave port and the
//   grant vector of io_bus_arbiter.
//   Ports (signals):
//     m0_* / m1_* : read, write, address, writedata (requester -> arbiter)
//                   readdata, waitrequest, error     (arbiter -> requester)
//     s_*         : chipselect, read, write, address, writedata (arbiter -> slave)
//                   readdata, waitrequest                      (slave -> arbiter)
//     grant       : one-hot owner of the slave, 00 when idle
//   Modports:
//     slave  : the arbiter's view (it is the slave of both requesters)
//     master : the environment's view (requesters plus the shared slave)
interface io_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  m0_read;
  logic                  m0_write;
  logic [ADDR_WIDTH-1:0] m0_address;
  logic [DATA_WIDTH-1:0] m0_writedata;
  logic [DATA_WIDTH-1:0] m0_readdata;
  logic                  m0_waitrequest;
  logic                  m0_error;

  logic                  m1_read;
  logic                  m1_write;
  logic [ADDR_WIDTH-1:0] m1_address;
  logic [DATA_WIDTH-1:0] m1_writedata;
  logic [DATA_WIDTH-1:0] m1_readdata;
  logic                  m1_waitrequest;
  logic                  m1_error;

  logic                  s_chipselect;
  logic                  s_read;
  logic                  s_write;
  logic [ADDR_WIDTH-1:0] s_address;
  logic [DATA_WIDTH-1:0] s_writedata;
  logic [DATA_WIDTH-1:0] s_readdata;
  logic                  s_waitrequest;

  logic [1:0]            grant;

  modport slave (
    input  m0_read, m0_write, m0_address, m0_writedata,
    output m0_readdata, m0_waitrequest, m0_error,
    input  m1_read, m1_write, m1_address, m1_writedata,
    output m1_readdata, m1_waitrequest, m1_error,
    output s_chipselect, s_read, s_write, s_address, s_writedata,
    input  s_readdata, s_waitrequest,
    output grant
  );

  modport master (
    output m0_read, m0_write, m0_address, m0_writedata,
    input  m0_readdata, m0_waitrequest, m0_error,
    output m1_read, m1_write, m1_address, m1_writedata,
    input  m1_readdata, m1_waitrequest, m1_error,
    input  s_chipselect, s_read, s_write, s_address, s_writedata,
    output s_readdata, s_waitrequest,
    input  grant
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares one Avalon-MM slave port between requester 0 (HPS bridge) and
//   requester 1 (game logic). One transaction at a time, round-robin on ties,
//   completion and read data go to the winner only. Minimum 3 cycles per
//   transaction (IDLE -> ACCESS -> DONE).
//   Ports:
//     clk : clock
//     rst : synchronous active-high reset
//     bus : io_bus_arbiter_if.slave (requester ports, slave port, grant)
//   Optional feature: define IO_ARB_TIMEOUT_EN to abort accesses that stall
//   for TIMEOUT_CYCLES cycles (error flag, all-ones read data). Without it the
//   arbiter waits forever and the error outputs are tied low.
module io_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  io_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("io_bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t                state_reg, state_next;
  logic [1:0]            grant_reg;
  logic                  ptr_reg;      // last served requester
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  logic [1:0]            req_read, req_write, pending, waitreq, err;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [DATA_WIDTH-1:0] rdata_out [2];

  logic start, win, finish, abort, in_access, in_done;

  assign req_read     = {bus.m1_read, bus.m0_read};
  assign req_write    = {bus.m1_write, bus.m0_write};
  assign req_addr[0]  = bus.m0_address;
  assign req_addr[1]  = bus.m1_address;
  assign req_wdata[0] = bus.m0_writedata;
  assign req_wdata[1] = bus.m1_writedata;

  assign in_access = (state_reg == ACCESS);
  assign in_done   = (state_reg == DONE);

`ifdef IO_ARB_TIMEOUT_EN
  logic [7:0] stall_reg;
  logic       err_reg;

  // Abort on the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign abort = in_access & bus.s_waitrequest &
                 (stall_reg == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (start)
        stall_reg <= '0;
      else if (in_access && bus.s_waitrequest)
        stall_reg <= stall_reg + 8'd1;
      if (finish)
        err_reg <= abort;
    end
  end
`else
  assign abort = 1'b0;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [DATA_WIDTH-1:0] rdata_reg;

    assign pending[gi] = req_read[gi] | req_write[gi];
    // Low only in the winner's DONE cycle, and whenever not requesting.
    assign waitreq[gi] = pending[gi] & ~(in_done & grant_reg[gi]);
`ifdef IO_ARB_TIMEOUT_EN
    assign err[gi] = err_reg & in_done & grant_reg[gi];
`else
    assign err[gi] = 1'b0;
`endif

    // Captured at completion so it is stable in DONE and held afterwards.
    always_ff @(posedge clk) begin
      if (rst)
        rdata_reg <= '0;
      else if (finish && grant_reg[gi])
        rdata_reg <= abort ? '1 : (write_reg ? '0 : bus.s_readdata);
    end

    assign rdata_out[gi] = rdata_reg;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    win        = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|pending) begin
          start      = 1'b1;
          // On a tie the requester not served last wins.
          win        = (&pending) ? ~ptr_reg : pending[1];
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.s_waitrequest || abort) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= 2'b00;
      ptr_reg   <= 1'b1;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        grant_reg <= win ? 2'b10 : 2'b01;
        write_reg <= req_write[win];   // read+write together counts as write
        addr_reg  <= req_addr[win];
        wdata_reg <= req_wdata[win];
      end else if (in_done) begin
        grant_reg <= 2'b00;
      end
      if (finish)
        ptr_reg <= grant_reg[1];
    end
  end

  assign bus.s_chipselect = in_access;
  assign bus.s_read       = in_access & ~write_reg;
  assign bus.s_write      = in_access & write_reg;
  assign bus.s_address    = in_access ? addr_reg : '0;
  assign bus.s_writedata  = in_access ? wdata_reg : '0;

  assign bus.grant          = grant_reg;
  assign bus.m0_waitrequest = waitreq[0];
  assign bus.m1_waitrequest = waitreq[1];
  assign bus.m0_readdata    = rdata_out[0];
  assign bus.m1_readdata    = rdata_out[1];
  assign bus.m0_error       = err[0];
  assign bus.m1_error       = err[1];
endmodule
